// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for a single shared ULA.
// Captures the winner's operands, waits one cycle for the ULA, then returns a latched result.
module ula_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  op0,
   input  logic [3:0]  op1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   input  logic [4:0]  sh0,
   input  logic [4:0]  sh1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] rdata,
   output logic        rzero,
   output logic        busy,
   output logic [31:0] ula_in1,
   output logic [31:0] ula_in2,
   output logic [3:0]  ula_op,
   output logic [4:0]  ula_shamt,
   input  logic [31:0] ula_result,
   input  logic        ula_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nxt;
   logic   last;
   logic   any_req;
   logic   pick1;

   assign any_req = req0 | req1;
   // On a tie the requester that did not win last time takes the ULA.
   assign pick1   = req1 & (~req0 | ~last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last      <= 1'b1;
         ula_in1   <= '0;
         ula_in2   <= '0;
         ula_op    <= '0;
         ula_shamt <= '0;
         rdata     <= '0;
         rzero     <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            last      <= pick1;
            ula_in1   <= pick1 ? a1  : a0;
            ula_in2   <= pick1 ? b1  : b0;
            ula_op    <= pick1 ? op1 : op0;
            ula_shamt <= pick1 ? sh1 : sh0;
         end
         if (state == EXEC) begin
            rdata <= ula_result;
            rzero <= ula_zero;
         end
      end
   end

   // gnt/done are decoded from state and the registered winner, so reset clears them at once.
   always_comb begin
      gnt0  = (state == EXEC) & ~last;
      gnt1  = (state == EXEC) &  last;
      done0 = (state == RESP) & ~last;
      done1 = (state == RESP) &  last;
      busy  = (state != IDLE);
   end

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed as below (clock and reset first).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0, req1  input  1 each  request from requester 0 / 1; held high with operands stable until that requester's gnt is seen.
REQ-005 op0, op1  input  4 each  ALU operation code of requester 0 / 1; uses the existing ULA OP encoding and is passed through unchanged.
REQ-006 a0, b0, a1, b1  input  32 each  In1 / In2 operands of requester 0 / 1.
REQ-007 sh0, sh1  input  5 each  shamt of requester 0 / 1.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: operands captured for that requester.
REQ-009 done0, done1  output  1 each  one-cycle pulse: rdata/rzero valid for that requester.
REQ-010 rdata  output  32  latched ALU result.
REQ-011 rzero  output  1  latched ALU Zero_flag.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 ula_in1, ula_in2  output  32 each  drive the shared ULA In1 / In2.
REQ-014 ula_op  output  4  drives the ULA OP.
REQ-015 ula_shamt  output  5  drives the ULA shamt.
REQ-016 ula_result  input  32  ULA result.
REQ-017 ula_zero  input  1  ULA Zero_flag.

Function
REQ-018 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-019 IDLE, no req: remain in IDLE; all pulses low; ULA drive outputs and rdata/rzero hold their values.
REQ-020 IDLE, at least one req at a rising edge: the block SHALL select a winner, latch its op/a/b/sh into the ULA drive registers, set the winner's gnt, set last := winner, and go to EXEC.
REQ-021 Winner selection: single request -> that requester; both -> the requester not equal to last (round-robin).
REQ-022 EXEC, at its closing edge: rdata := ula_result, rzero := ula_zero, winner's done := 1, gnt := 0, go to RESP.
REQ-023 RESP, at its closing edge: done := 0, go to IDLE.
REQ-024 Latency: gnt is visible in the cycle after the accepting edge (N+1), done/rdata in N+2, and busy is low again in N+3.
REQ-025 Throughput: at most one operation per 3 cycles; requests are not sampled in EXEC or RESP.
REQ-026 gnt and done SHALL be one-hot or zero, and SHALL never be high in the same cycle.
REQ-027 ULA drive registers SHALL be stable from the gnt cycle through the done cycle.
REQ-028 op values SHALL be forwarded unmodified; undefined codes are not trapped.
REQ-029 A req withdrawn in IDLE before an edge SHALL NOT be granted, and no partial state SHALL remain.
REQ-030 A request that is still high in RESP SHALL be arbitrated normally at the first IDLE edge.

Reset
REQ-031 While rst_n is low, regardless of clk: state = IDLE, last = 1 (requester 0 wins the first tie), gnt0/1 = 0, done0/1 = 0, busy = 0, rdata = 0, rzero = 0, ula_in1/in2 = 0, ula_op = 0, ula_shamt = 0.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the operation with no done pulse, and SHALL NOT emit a grant on release unless req is sampled high at a later edge.

Verification
REQ-033 Single request: req0 with op=0010, a0=5, b0=7 -> gnt0 at N+1, done0 at N+2, rdata=12, rzero=0, busy low at N+3.
REQ-034 Zero flag: req1 with op=0110, a1=b1=0x1234 -> done1 with rdata=0, rzero=1.
REQ-035 Round-robin: req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1, with one grant every 3 cycles.
REQ-036 Shift pass-through: req0 with op=0100, b0=0x80000000, sh0=4 -> rdata=0xF8000000; ula_shamt=4 in the gnt and done cycles.
REQ-037 Reset mid-operation: assert rst_n low during EXEC -> all outputs zero immediately, no done pulse; after release with req0 high, a normal grant follows.
REQ-038 Withdrawn request: req1 pulsed high between edges only -> no gnt1 and busy stays low.
